// File: rtl/weight_sched_pkg.sv
// weight_sched_pkg: shared state encoding, default BRAM latency and layer region bases.
package weight_sched_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;
  localparam int BRAM_READ_LATENCY = 2;
  localparam int LAYER1_1_BASE = 0;
  localparam int LAYER1_2_BASE = 9216;
  localparam int LAYER1_3_BASE = 18432;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id,
  output logic           any
);
  assign any = |req;
  // Scan downward so the smallest offset from ptr is the last one written.
  always_comb begin
    gnt = '0;
    id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = N'(1) << ((int'(ptr) + i) % N);
        id  = IDW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/weight_bram_scheduler.sv
// weight_bram_scheduler: round-robin sharing of one read-only weight BRAM port between requesters.
// WEIGHT_SCHED_CHECKSUM_EN adds a per-transfer sum of returned words on the checksum port.
module weight_bram_scheduler
  import weight_sched_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int W            = 8,
  parameter int ADDR_WIDTH   = 18,
  parameter int CNT_WIDTH    = 19,
  parameter int READ_LATENCY = BRAM_READ_LATENCY,
  parameter int ID_WIDTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_LAYERS-1:0]            req,
  input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] base_addr,
  input  logic [NUM_LAYERS*CNT_WIDTH-1:0]  length,
  output logic [NUM_LAYERS-1:0]            grant,
  output logic                             bram_en,
  output logic                             bram_ren,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  input  logic [W-1:0]                     bram_dout,
  output logic                             wr_valid,
  output logic [ID_WIDTH-1:0]              wr_id,
  output logic [CNT_WIDTH-1:0]             wr_index,
  output logic [W-1:0]                     wr_data,
  output logic [NUM_LAYERS-1:0]            done,
  output logic                             busy
`ifdef WEIGHT_SCHED_CHECKSUM_EN
  ,
  output logic [W+CNT_WIDTH-1:0]           checksum
`endif
);
  state_t state_q, state_d;
  logic [NUM_LAYERS-1:0] grant_q, grant_d, arb_gnt;
  logic [ID_WIDTH-1:0] owner_q, owner_d, rr_q, rr_d, arb_id;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0][CNT_WIDTH-1:0] idx_q, idx_d;
  logic arb_any, last_issue;
  rr_arbiter #(.N(NUM_LAYERS), .IDW(ID_WIDTH)) u_arb (
    .req(req),
    .ptr(rr_q),
    .gnt(arb_gnt),
    .id(arb_id),
    .any(arb_any)
  );
  assign busy       = state_q != IDLE;
  assign bram_en    = busy;
  assign grant      = grant_q;
  assign bram_ren   = state_q == ISSUE && cnt_q != len_q;
  assign bram_addr  = bram_ren ? base_q + ADDR_WIDTH'(cnt_q) : '0;
  // Widened compare so a zero-length transfer also leaves ISSUE without issuing.
  assign last_issue = {1'b0, cnt_q} + 1'b1 >= {1'b0, len_q};
  assign wr_valid   = vld_q[READ_LATENCY-1];
  assign wr_index   = wr_valid ? idx_q[READ_LATENCY-1] : '0;
  assign wr_data    = wr_valid ? bram_dout : '0;
  assign wr_id      = owner_q;
  assign done       = state_q == FINISH ? grant_q : '0;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    vld_d   = READ_LATENCY'({vld_q, bram_ren});
    idx_d   = idx_q;
    idx_d[0] = cnt_q;
    for (int i = 1; i < READ_LATENCY; i++) idx_d[i] = idx_q[i-1];
    case (state_q)
      IDLE: if (arb_any) begin
        state_d = ISSUE;
        grant_d = arb_gnt;
        owner_d = arb_id;
        base_d  = base_addr[int'(arb_id)*ADDR_WIDTH +: ADDR_WIDTH];
        len_d   = length[int'(arb_id)*CNT_WIDTH +: CNT_WIDTH];
        cnt_d   = '0;
      end
      ISSUE: begin
        cnt_d   = bram_ren ? cnt_q + 1'b1 : cnt_q;
        state_d = last_issue ? DRAIN : ISSUE;
      end
      DRAIN: state_d = vld_q == '0 ? FINISH : DRAIN;
      FINISH: begin
        state_d = IDLE;
        grant_d = '0;
        rr_d    = owner_q == ID_WIDTH'(NUM_LAYERS - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end
`ifdef WEIGHT_SCHED_CHECKSUM_EN
  logic [W+CNT_WIDTH-1:0] sum_q, sum_d;
  assign checksum = sum_q;
  always_comb sum_d = (state_q == IDLE && arb_any) ? '0 :
                      wr_valid ? sum_q + (W+CNT_WIDTH)'(wr_data) : sum_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif
endmodule

// File: tb/tb_weight_bram_scheduler.sv
// tb_weight_bram_scheduler: scoreboard bench; grant-time expectations are popped as addresses and words appear.
module tb_weight_bram_scheduler;
  localparam int NL = 4;
  localparam int W  = 8;
  localparam int AW = 18;
  localparam int CW = 19;
  localparam int RL = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NL-1:0] req = '0;
  logic [NL*AW-1:0] base_addr;
  logic [NL*CW-1:0] length;
  logic [NL-1:0] grant, done;
  logic bram_en, bram_ren, wr_valid, busy;
  logic [AW-1:0] bram_addr;
  logic [W-1:0] bram_dout = '0, wr_data, d1 = '0;
  logic [IW-1:0] wr_id;
  logic [CW-1:0] wr_index;
`ifdef WEIGHT_SCHED_CHECKSUM_EN
  logic [W+CW-1:0] checksum;
  logic [W+CW-1:0] exp_sum;
`endif

  logic [AW-1:0] cfg_base[NL];
  logic [CW-1:0] cfg_len[NL];
  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int ren_count = 0;
  int gcyc = 0;
  int cur_len = 0;
  logic [NL-1:0] prev_g = '0;
  logic [NL-1:0] cur_g = '0;
  int order_q[$];
  logic [AW-1:0] addr_q[$];
  logic [IW+CW+W-1:0] word_q[$];

  weight_bram_scheduler #(
    .NUM_LAYERS(NL), .W(W), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .READ_LATENCY(RL), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .base_addr(base_addr), .length(length),
    .grant(grant), .bram_en(bram_en), .bram_ren(bram_ren), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .wr_valid(wr_valid), .wr_id(wr_id), .wr_index(wr_index),
    .wr_data(wr_data), .done(done), .busy(busy)
`ifdef WEIGHT_SCHED_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NL; i++) begin
      base_addr[i*AW +: AW] = cfg_base[i];
      length[i*CW +: CW]    = cfg_len[i];
    end
  end

  function automatic logic [W-1:0] mem(input logic [AW-1:0] a);
    return W'(a + 18'd1);
  endfunction

  // Two-stage read model of the BRAM.
  always @(posedge clk) begin
    d1 <= bram_ren ? mem(bram_addr) : '0;
    bram_dout <= d1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      addr_q.delete();
      word_q.delete();
      prev_g = '0;
    end else begin
      if (grant != 0 && prev_g == 0) begin
        int e;
        e = order_q.size() > 0 ? order_q.pop_front() : -1;
        cur_g = e >= 0 ? NL'(1) << e : '0;
        check("grant", 64'(grant), 64'(cur_g));
        gcyc = 0;
`ifdef WEIGHT_SCHED_CHECKSUM_EN
        exp_sum = '0;
`endif
        if (e >= 0) begin
          cur_len = int'(cfg_len[e]);
          for (int k = 0; k < cur_len; k++) begin
            logic [AW-1:0] a;
            a = cfg_base[e] + AW'(k);
            addr_q.push_back(a);
            word_q.push_back({IW'(e), CW'(k), mem(a)});
          end
        end
      end else if (grant != 0) gcyc++;
      if (bram_ren) begin
        ren_count++;
        check("ren_expected", 64'(addr_q.size() > 0), 64'd1);
        if (addr_q.size() > 0) check("addr", 64'(bram_addr), 64'(addr_q.pop_front()));
      end
      if (wr_valid) begin
        check("wr_expected", 64'(word_q.size() > 0), 64'd1);
        if (word_q.size() > 0) begin
          logic [IW+CW+W-1:0] w;
          w = word_q.pop_front();
          check("wr_word", 64'({wr_id, wr_index, wr_data}), 64'(w));
`ifdef WEIGHT_SCHED_CHECKSUM_EN
          exp_sum = exp_sum + (W+CW)'(w[W-1:0]);
`endif
        end
      end
      if (done != 0) begin
        check("done_bit", 64'(done), 64'(cur_g));
        check("latency", 64'(gcyc), 64'(cur_len == 0 ? 2 : cur_len + RL + 1));
        check("words_left", 64'(addr_q.size() + word_q.size()), 64'd0);
`ifdef WEIGHT_SCHED_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(exp_sum));
`endif
        done_count++;
      end
      prev_g = grant;
    end
  end

  task automatic wait_grant();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (grant == 0 && n < 100);
    if (grant == 0) check("timeout_grant", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_count < target && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_count < target) check("timeout_done", 64'(done_count), 64'(target));
  endtask

  task automatic run_single(input int id, input logic [AW-1:0] b, input logic [CW-1:0] l);
    int start = done_count;
    cfg_base[id] = b;
    cfg_len[id] = l;
    order_q.push_back(id);
    req[id] = 1'b1;
    wait_grant();
    req = '0;
    cfg_base[id] = b + 18'd77;
    cfg_len[id] = l;
    wait_done(start + 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int start;
    for (int i = 0; i < NL; i++) begin
      cfg_base[i] = '0;
      cfg_len[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(bram_en), 64'd0);
    check("rst_ren", 64'(bram_ren), 64'd0);
    check("rst_addr", 64'(bram_addr), 64'd0);
    check("rst_wr", 64'({wr_valid, wr_index, wr_data}), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    cfg_base[0] = 18'd0;     cfg_len[0] = 19'd3;
    cfg_base[1] = 18'd9216;  cfg_len[1] = 19'd3;
    cfg_base[2] = 18'd18432; cfg_len[2] = 19'd3;
    cfg_base[3] = 18'd30000; cfg_len[3] = 19'd3;
    foreach (order_q[i]) order_q.delete(i);
    order_q = '{0, 1, 2, 3, 0};
    start = done_count;
    req = 4'b1111;
    wait_done(start + 5);
    req = '0;
    repeat (4) @(negedge clk);
    #1;
    check("contention_dones", 64'(done_count), 64'(start + 5));
    check("idle_after", 64'(busy), 64'd0);

    run_single(1, 18'd18432, 19'd8);
    run_single(2, 18'd500, 19'd0);
    run_single(3, 18'd262142, 19'd4);
    run_single(1, 18'd1000, 19'd2);

    cfg_base[2] = 18'd100;
    cfg_len[2] = 19'd10;
    order_q.push_back(2);
    req = 4'b0100;
    wait_grant();
    req = '0;
    start = ren_count;
    for (int n = 0; n < 50 && ren_count < start + 5; n++) begin
      @(negedge clk); #1;
    end
    check("mid_ren_count", 64'(ren_count), 64'(start + 5));
    start = done_count;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ren", 64'(bram_ren), 64'd0);
    check("mid_rst_wr", 64'(wr_valid), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    order_q.delete();
    repeat (4) @(negedge clk);
    #1;
    check("no_done_after_rst", 64'(done_count), 64'(start));
    order_q.push_back(0);
    req = 4'b0101;
    wait_grant();
    req = '0;
    wait_done(start + 1);
    repeat (3) @(negedge clk);
    check("order_drained", 64'(order_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
